// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm ringer and the board I/O side.
// The slave modport is the ringer's view. The master modport is the view of
// whatever drives tick, alarm match and buttons and reads the status.
interface alarm_ringer_if #(
   parameter int CNT_W = 2
);
   logic             tick_i;
   logic             alarm_hit_i;
   logic             arm_i;
   logic             snooze_btn_i;
   logic             stop_btn_i;
   logic             buzzer_o;
   logic             ringing_o;
   logic             snoozing_o;
   logic [CNT_W-1:0] snooze_cnt_o;
   logic             missed_o;

   modport master (
      output tick_i, alarm_hit_i, arm_i, snooze_btn_i, stop_btn_i,
      input  buzzer_o, ringing_o, snoozing_o, snooze_cnt_o, missed_o
   );

   modport slave (
      input  tick_i, alarm_hit_i, arm_i, snooze_btn_i, stop_btn_i,
      output buzzer_o, ringing_o, snoozing_o, snooze_cnt_o, missed_o
   );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm session controller: ring, snooze and stop, with a pulsed buzzer.
// It follows the time-of-day counter and runs on the same clock.
// Optional build macro ALARM_ESCALATE_EN: in the second half of each ring
// period the buzzer is held steadily on instead of pulsing.
//
// state  | meaning
// IDLE   | no session active; snooze_cnt/missed keep last session's result
// RING   | buzzer pulsing on tick; counts toward auto-stop timeout
// SNOOZE | silent; counts down the snooze interval, then rings again
module alarm_ringer #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int MAX_SNOOZES    = 3
) (
   input logic         clk,
   input logic         reset,
   alarm_ringer_if.slave bus
);
   localparam int RT_W  = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
   localparam int ST_W  = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;
   localparam int CNT_W = $clog2(MAX_SNOOZES + 1);

   localparam logic [RT_W-1:0]  RING_LAST   = RT_W'(RING_TIMEOUT_S - 1);
   localparam logic [ST_W-1:0]  SNOOZE_LAST = ST_W'(SNOOZE_S - 1);
   localparam logic [CNT_W-1:0] SNOOZE_MAX  = CNT_W'(MAX_SNOOZES);
`ifdef ALARM_ESCALATE_EN
   localparam logic [RT_W-1:0]  ESCALATE_AT = RT_W'(RING_TIMEOUT_S / 2);
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              snooze_prev_q, stop_prev_q;
   logic [RT_W-1:0]   ring_timer_q, ring_timer_d;
   logic [ST_W-1:0]   snooze_timer_q, snooze_timer_d;
   logic [CNT_W-1:0]  snooze_cnt_q, snooze_cnt_d;
   logic              phase_q, phase_d;
   logic              missed_q, missed_d;
   logic              buzzer_q, buzzer_d;
   logic              ringing_q, ringing_d;
   logic              snoozing_q, snoozing_d;

   logic              snooze_ev, stop_ev;
   logic              start_session, take_snooze, ring_timeout, ring_step;
   logic              snooze_done, snooze_step;

   // A held button counts once: only the low-to-high transition is an event.
   assign snooze_ev = bus.snooze_btn_i & ~snooze_prev_q;
   assign stop_ev   = bus.stop_btn_i & ~stop_prev_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode; the branch flags below steer the datapath updates.
   always_comb begin
      state_d       = state_q;
      start_session = 1'b0;
      take_snooze   = 1'b0;
      ring_timeout  = 1'b0;
      ring_step     = 1'b0;
      snooze_done   = 1'b0;
      snooze_step   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.arm_i && bus.alarm_hit_i) begin
               state_d       = RING;
               start_session = 1'b1;
            end
         end
         RING: begin
            if (!bus.arm_i || stop_ev) begin
               state_d = IDLE;
            end else if (snooze_ev && (snooze_cnt_q < SNOOZE_MAX)) begin
               state_d     = SNOOZE;
               take_snooze = 1'b1;
            end else if (bus.tick_i) begin
               if (ring_timer_q == RING_LAST) begin
                  state_d      = IDLE;
                  ring_timeout = 1'b1;
               end else begin
                  ring_step = 1'b1;
               end
            end
         end
         SNOOZE: begin
            if (!bus.arm_i || stop_ev) begin
               state_d = IDLE;
            end else if (bus.tick_i) begin
               if (snooze_timer_q == SNOOZE_LAST) begin
                  state_d     = RING;
                  snooze_done = 1'b1;
               end else begin
                  snooze_step = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      ring_timer_d   = ring_timer_q;
      snooze_timer_d = snooze_timer_q;
      snooze_cnt_d   = snooze_cnt_q;
      phase_d        = phase_q;
      missed_d       = missed_q;
      if (start_session) begin
         ring_timer_d = '0;
         snooze_cnt_d = '0;
         phase_d      = 1'b1;
         missed_d     = 1'b0;
      end
      if (take_snooze) begin
         snooze_cnt_d   = snooze_cnt_q + CNT_W'(1);
         snooze_timer_d = '0;
      end
      if (ring_step) begin
         ring_timer_d = ring_timer_q + RT_W'(1);
         phase_d      = ~phase_q;
      end
      if (snooze_done) begin
         ring_timer_d = '0;
         phase_d      = 1'b1;
      end
      if (snooze_step) begin
         snooze_timer_d = snooze_timer_q + ST_W'(1);
      end
      if (ring_timeout) missed_d = 1'b1;
      // A stop press acknowledges a missed alarm even when nothing is ringing.
      if (stop_ev) missed_d = 1'b0;

      ringing_d  = (state_d == RING);
      snoozing_d = (state_d == SNOOZE);
`ifdef ALARM_ESCALATE_EN
      buzzer_d   = (state_d == RING) && (phase_d || (ring_timer_d >= ESCALATE_AT));
`else
      buzzer_d   = (state_d == RING) && phase_d;
`endif
   end

   // Datapath, button history and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snooze_prev_q  <= 1'b0;
         stop_prev_q    <= 1'b0;
         ring_timer_q   <= '0;
         snooze_timer_q <= '0;
         snooze_cnt_q   <= '0;
         phase_q        <= 1'b0;
         missed_q       <= 1'b0;
         buzzer_q       <= 1'b0;
         ringing_q      <= 1'b0;
         snoozing_q     <= 1'b0;
      end else begin
         snooze_prev_q  <= bus.snooze_btn_i;
         stop_prev_q    <= bus.stop_btn_i;
         ring_timer_q   <= ring_timer_d;
         snooze_timer_q <= snooze_timer_d;
         snooze_cnt_q   <= snooze_cnt_d;
         phase_q        <= phase_d;
         missed_q       <= missed_d;
         buzzer_q       <= buzzer_d;
         ringing_q      <= ringing_d;
         snoozing_q     <= snoozing_d;
      end
   end

   assign bus.buzzer_o     = buzzer_q;
   assign bus.ringing_o    = ringing_q;
   assign bus.snoozing_o   = snoozing_q;
   assign bus.snooze_cnt_o = snooze_cnt_q;
   assign bus.missed_o     = missed_q;
endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with short timeouts (ring 6, snooze 4, 2 snoozes).
module tb_alarm_ringer;
   localparam int RT = 6;
   localparam int SN = 4;
   localparam int MS = 2;
   localparam int CW = $clog2(MS + 1);

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   alarm_ringer_if #(.CNT_W(CW)) bus ();

   alarm_ringer #(
      .RING_TIMEOUT_S(RT),
      .SNOOZE_S(SN),
      .MAX_SNOOZES(MS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Advance n clock edges and settle 1 time unit past the last one.
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse alarm_hit for one cycle; returns in the first RING cycle.
   task automatic start_ring();
      bus.alarm_hit_i = 1'b1;
      step();
      bus.alarm_hit_i = 1'b0;
   endtask

   task automatic press_snooze();
      bus.snooze_btn_i = 1'b1;
      step();
      bus.snooze_btn_i = 1'b0;
   endtask

   task automatic press_stop();
      bus.stop_btn_i = 1'b1;
      step();
      bus.stop_btn_i = 1'b0;
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      bus.tick_i       = 1'b1;
      bus.alarm_hit_i  = 1'b0;
      bus.arm_i        = 1'b1;
      bus.snooze_btn_i = 1'b0;
      bus.stop_btn_i   = 1'b0;
      step(2);
      checks++;
      if ({bus.buzzer_o, bus.ringing_o, bus.snoozing_o, bus.missed_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {bus.buzzer_o, bus.ringing_o, bus.snoozing_o, bus.missed_o});
      end
      checks++;
      if (bus.snooze_cnt_o !== '0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d expected 0", bus.snooze_cnt_o);
      end
      reset = 1'b0;
      step(9);
   endtask

   task automatic test_ring_timeout();
`ifdef ALARM_ESCALATE_EN
      int exp_b[6] = '{1, 0, 1, 1, 1, 1};
`else
      int exp_b[6] = '{1, 0, 1, 0, 1, 0};
`endif
      start_ring();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.ringing_o !== 1'b1 || bus.buzzer_o !== exp_b[i][0]) begin
            errors++;
            $display("FAIL timeout_ring[%0d]: ringing=%b buzzer=%b expected ringing=1 buzzer=%0d",
                     i, bus.ringing_o, bus.buzzer_o, exp_b[i]);
         end
         step();
      end
      checks++;
      if (bus.ringing_o !== 1'b0 || bus.missed_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_end: ringing=%b missed=%b expected 0/1", bus.ringing_o, bus.missed_o);
      end
      press_stop();
      checks++;
      if (bus.missed_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_stop_clears_missed: got %b expected 0", bus.missed_o);
      end
   endtask

   task automatic test_snooze();
      start_ring();
      step(2);
      press_snooze();
      checks++;
      if (bus.snoozing_o !== 1'b1 || bus.ringing_o !== 1'b0 || bus.buzzer_o !== 1'b0 ||
          bus.snooze_cnt_o !== CW'(1)) begin
         errors++;
         $display("FAIL snooze_enter: snoozing=%b ringing=%b buzzer=%b cnt=%0d expected 1/0/0/1",
                  bus.snoozing_o, bus.ringing_o, bus.buzzer_o, bus.snooze_cnt_o);
      end
      step(3);
      checks++;
      if (bus.snoozing_o !== 1'b1) begin
         errors++;
         $display("FAIL snooze_hold: snoozing=%b expected 1", bus.snoozing_o);
      end
      step();
      checks++;
      if (bus.ringing_o !== 1'b1 || bus.buzzer_o !== 1'b1 || bus.snoozing_o !== 1'b0) begin
         errors++;
         $display("FAIL snooze_return: ringing=%b buzzer=%b snoozing=%b expected 1/1/0",
                  bus.ringing_o, bus.buzzer_o, bus.snoozing_o);
      end
      press_stop();
   endtask

   task automatic test_snooze_limit();
      start_ring();
      press_snooze();
      step(4);
      press_snooze();
      checks++;
      if (bus.snoozing_o !== 1'b1 || bus.snooze_cnt_o !== CW'(2)) begin
         errors++;
         $display("FAIL second_snooze: snoozing=%b cnt=%0d expected 1/2", bus.snoozing_o, bus.snooze_cnt_o);
      end
      step(4);
      checks++;
      if (bus.ringing_o !== 1'b1) begin
         errors++;
         $display("FAIL third_ring: ringing=%b expected 1", bus.ringing_o);
      end
      press_snooze();
      checks++;
      if (bus.ringing_o !== 1'b1 || bus.snoozing_o !== 1'b0 || bus.snooze_cnt_o !== CW'(2)) begin
         errors++;
         $display("FAIL snooze_limit: ringing=%b snoozing=%b cnt=%0d expected 1/0/2",
                  bus.ringing_o, bus.snoozing_o, bus.snooze_cnt_o);
      end
      press_stop();
      checks++;
      if (bus.ringing_o !== 1'b0 || bus.missed_o !== 1'b0 || bus.snooze_cnt_o !== CW'(2)) begin
         errors++;
         $display("FAIL stop_after_limit: ringing=%b missed=%b cnt=%0d expected 0/0/2",
                  bus.ringing_o, bus.missed_o, bus.snooze_cnt_o);
      end
      step(3);
      checks++;
      if (bus.snooze_cnt_o !== CW'(2)) begin
         errors++;
         $display("FAIL cnt_hold_idle: cnt=%0d expected 2", bus.snooze_cnt_o);
      end
   endtask

   task automatic test_arm();
      bus.arm_i = 1'b0;
      start_ring();
      checks++;
      if (bus.ringing_o !== 1'b0 || bus.snooze_cnt_o !== CW'(2)) begin
         errors++;
         $display("FAIL disarmed_hit: ringing=%b cnt=%0d expected 0/2", bus.ringing_o, bus.snooze_cnt_o);
      end
      bus.arm_i = 1'b1;
      step();
      start_ring();
      press_snooze();
      step();
      bus.arm_i = 1'b0;
      step();
      checks++;
      if (bus.snoozing_o !== 1'b0 || bus.ringing_o !== 1'b0) begin
         errors++;
         $display("FAIL disarm_in_snooze: snoozing=%b ringing=%b expected 0/0",
                  bus.snoozing_o, bus.ringing_o);
      end
      bus.arm_i = 1'b1;
      step();
      start_ring();
      step(2);
      bus.alarm_hit_i = 1'b1;
      step();
      bus.alarm_hit_i = 1'b0;
      step(2);
      checks++;
      if (bus.ringing_o !== 1'b1) begin
         errors++;
         $display("FAIL hit_in_ring_last: ringing=%b expected 1", bus.ringing_o);
      end
      step();
      checks++;
      if (bus.ringing_o !== 1'b0 || bus.missed_o !== 1'b1) begin
         errors++;
         $display("FAIL hit_in_ring_timeout: ringing=%b missed=%b expected 0/1",
                  bus.ringing_o, bus.missed_o);
      end
   endtask

   task automatic test_stop_vs_snooze();
      start_ring();
      checks++;
      if (bus.missed_o !== 1'b0 || bus.snooze_cnt_o !== '0) begin
         errors++;
         $display("FAIL session_start_clear: missed=%b cnt=%0d expected 0/0",
                  bus.missed_o, bus.snooze_cnt_o);
      end
      bus.stop_btn_i   = 1'b1;
      bus.snooze_btn_i = 1'b1;
      step();
      bus.stop_btn_i   = 1'b0;
      bus.snooze_btn_i = 1'b0;
      checks++;
      if (bus.ringing_o !== 1'b0 || bus.snoozing_o !== 1'b0 || bus.snooze_cnt_o !== '0) begin
         errors++;
         $display("FAIL stop_wins: ringing=%b snoozing=%b cnt=%0d expected 0/0/0",
                  bus.ringing_o, bus.snoozing_o, bus.snooze_cnt_o);
      end
      step();
      start_ring();
      bus.snooze_btn_i = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 5) begin
            checks++;
            if (bus.ringing_o !== 1'b1 || bus.snooze_cnt_o !== CW'(1)) begin
               errors++;
               $display("FAIL held_snooze_return: ringing=%b cnt=%0d expected 1/1",
                        bus.ringing_o, bus.snooze_cnt_o);
            end
         end
      end
      checks++;
      if (bus.ringing_o !== 1'b1 || bus.snooze_cnt_o !== CW'(1)) begin
         errors++;
         $display("FAIL held_snooze_once: ringing=%b cnt=%0d expected 1/1",
                  bus.ringing_o, bus.snooze_cnt_o);
      end
      bus.snooze_btn_i = 1'b0;
      press_stop();
      checks++;
      if (bus.ringing_o !== 1'b0 || bus.missed_o !== 1'b0) begin
         errors++;
         $display("FAIL held_then_stop: ringing=%b missed=%b expected 0/0", bus.ringing_o, bus.missed_o);
      end
   endtask

   task automatic test_async_reset();
      step();
      start_ring();
      press_snooze();
      step(4);
      checks++;
      if (bus.ringing_o !== 1'b1 || bus.buzzer_o !== 1'b1 || bus.snooze_cnt_o !== CW'(1)) begin
         errors++;
         $display("FAIL pre_reset: ringing=%b buzzer=%b cnt=%0d expected 1/1/1",
                  bus.ringing_o, bus.buzzer_o, bus.snooze_cnt_o);
      end
      reset = 1'b1;
      #2;
      checks++;
      if ({bus.buzzer_o, bus.ringing_o, bus.missed_o} !== 3'b000 || bus.snooze_cnt_o !== '0) begin
         errors++;
         $display("FAIL async_reset: buzzer=%b ringing=%b missed=%b cnt=%0d expected all 0",
                  bus.buzzer_o, bus.ringing_o, bus.missed_o, bus.snooze_cnt_o);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_ring_timeout();
      test_snooze();
      test_snooze_limit();
      test_arm();
      test_stop_vs_snooze();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
Downstream stage of the time-of-day counter. It consumes the one-cycle alarm-match flag and the seconds tick, and runs the user-facing alarm session: ringing, snooze and stop. It drives a pulsed buzzer and status flags to the board I/O. Same clock domain as the time counter.

Parameters:
RING_TIMEOUT_S, 60, seconds a ring session lasts before auto-stop (>=2)
SNOOZE_S, 300, snooze duration in seconds (>=1)
MAX_SNOOZES, 3, snoozes allowed per alarm session (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-second enable; tie 1 when clk is 1 Hz
alarm_hit  input  1  alarm-match flag from the time counter
arm  input  1  alarm enable switch (level)
snooze_btn  input  1  snooze button (level, already synchronised)
stop_btn  input  1  stop button (level, already synchronised)
buzzer  output  1  buzzer drive
ringing  output  1  high while state is RING
snoozing  output  1  high while state is SNOOZE
snooze_cnt  output  $clog2(MAX_SNOOZES+1)  snoozes used this session
missed  output  1  sticky: last session ended by timeout

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - State IDLE; all counters and button-history registers 0; beep phase 0.
- Button edges: a registered copy of each button is kept; an event is the rising edge (cur=1, prev=0).
- Holding a button generates one event only.
- All outputs are registered. alarm_hit or an edge sampled at cycle N is reflected on the outputs at N+1.
- States: IDLE, RING, SNOOZE.
- IDLE:
  - arm=1 and alarm_hit=1 -> RING.
  - On that entry: ring_timer=0, snooze_cnt=0, phase=1, missed=0.
  - alarm_hit with arm=0 is ignored.
- RING, evaluated in this priority order:
  1. arm=0 -> IDLE.
  2. stop edge -> IDLE.
  3. snooze edge with snooze_cnt<MAX_SNOOZES -> SNOOZE; snooze_cnt+1; snooze_timer=0.
     - With snooze_cnt==MAX_SNOOZES the snooze edge is ignored and ringing continues.
  4. tick with ring_timer==RING_TIMEOUT_S-1 -> IDLE; missed=1.
  5. Otherwise, on tick: ring_timer+1 and phase toggles.
- SNOOZE, evaluated in this priority order:
  1. arm=0 -> IDLE.
  2. stop edge -> IDLE.
  3. tick with snooze_timer==SNOOZE_S-1 -> RING; ring_timer=0; phase=1.
  4. Otherwise, on tick: snooze_timer+1.
  - Snooze edges are ignored.
- alarm_hit in RING or SNOOZE is ignored; no restart, no counter clear.
- buzzer = (state==RING) && phase.
- snooze_cnt:
  - Holds its value after return to IDLE, for display.
  - Cleared only on the next session start or on reset.
- missed:
  - Cleared by a new session start or by a stop edge in any state.
  - Stop/arm exits from RING leave missed at 0.
- Counters saturate logically by the state rules above; no wrap beyond the parameter limits.
- Timer widths: $clog2 of the respective parameter.
- Reset asserted mid-session forces IDLE immediately; buzzer drops asynchronously.

Optional Feature:
ALARM_ESCALATE_EN:
- Defined: in RING, once ring_timer >= RING_TIMEOUT_S/2 (integer divide), buzzer is held continuously high and phase toggling is ignored for the output. ring_timer resets on re-entry from SNOOZE, so escalation restarts each ring period.
- Undefined: buzzer always follows phase.

Test Plan:
1. Params RING_TIMEOUT_S=6, SNOOZE_S=4, MAX_SNOOZES=2; tick=1 every cycle; arm=1; pulse alarm_hit at cycle 10 -> cycle 11: ringing=1, buzzer=1. buzzer toggles 1,0,1,0,1,0 over cycles 11-16; cycle 17: ringing=0, missed=1.
2. Same setup; snooze edge at cycle 13 -> cycle 14: snoozing=1, snooze_cnt=1, buzzer=0. Ringing returns at cycle 18 with buzzer=1.
3. Snooze twice, then press snooze again in the third RING -> stays RING, snooze_cnt=2. A stop edge then gives ringing=0 next cycle, missed=0, snooze_cnt still 2.
4. arm=0 when alarm_hit pulses -> no state change. arm dropped during SNOOZE -> IDLE next cycle. alarm_hit during RING -> ring_timer not reset (timeout still at the original cycle).
5. Stop and snooze edges in the same cycle during RING -> IDLE (stop wins). Holding snooze_btn high for 10 cycles produces exactly one snooze.
6. Assert reset asynchronously mid-RING -> buzzer, ringing, snooze_cnt and missed all 0 without a clock edge. With ALARM_ESCALATE_EN and test-1 params, buzzer is 1,0,1,1,1,1 over cycles 11-16.
